// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
// The core owns the master side; the unit owns the slave side.
interface mult_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              i_start;
  logic [2:0]        i_op;
  logic [DATA_W-1:0] i_data_A;
  logic [DATA_W-1:0] i_data_B;
  logic              o_busy;
  logic              o_done;
  logic [DATA_W-1:0] o_hi;
  logic [DATA_W-1:0] o_lo;

  modport master (
    output i_start, i_op, i_data_A, i_data_B,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_data_A, i_data_B,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Works on operand magnitudes and applies the result signs in a final FIX cycle.
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input logic           i_clk,
  input logic           i_rst,
  mult_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic                is_div;
  logic                neg_q;
  logic                neg_r;
  logic                div_zero;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   mag_b;
  logic                busy;
  logic                done;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;

  logic                is_signed;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   in_mag_a;
  logic [DATA_W-1:0]   in_mag_b;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] acc_mul_next;
  logic [DATA_W:0]     rem_shift;
  logic [DATA_W:0]     rem_diff;
  logic [2*DATA_W-1:0] acc_div_next;
  logic [DATA_W-1:0]   rem_div_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_signed    = 1'b0;
    a_neg        = 1'b0;
    b_neg        = 1'b0;
    in_mag_a     = '0;
    in_mag_b     = '0;
    mul_sum      = '0;
    acc_mul_next = '0;
    rem_shift    = '0;
    rem_diff     = '0;
    acc_div_next = '0;
    rem_div_next = '0;

    // Signed ops have an even opcode; unsigned ones set bit 0.
    is_signed = ~bus.i_op[0];
    a_neg     = is_signed & bus.i_data_A[DATA_W-1];
    b_neg     = is_signed & bus.i_data_B[DATA_W-1];
    in_mag_a  = a_neg ? -bus.i_data_A : bus.i_data_A;
    in_mag_b  = b_neg ? -bus.i_data_B : bus.i_data_B;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    mul_sum      = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mag_b} : '0);
    acc_mul_next = {mul_sum, acc[DATA_W-1:1]};

    // Restoring divide: dividend shifts out of the low half, quotient bits shift in.
    rem_shift    = {rem, acc[DATA_W-1]};
    rem_diff     = rem_shift - {1'b0, mag_b};
    acc_div_next = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-2:0], ~rem_diff[DATA_W]};
    rem_div_next = rem_diff[DATA_W] ? rem_shift[DATA_W-1:0] : rem_diff[DATA_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      rem      <= '0;
      mag_b    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            if (!bus.i_op[2]) begin
              is_div   <= bus.i_op[1];
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div_zero <= (bus.i_data_B == '0);
              acc      <= {{DATA_W{1'b0}}, in_mag_a};
              rem      <= '0;
              mag_b    <= in_mag_b;
              count    <= CNT_W'(DATA_W);
              busy     <= 1'b1;
              state    <= CALC;
            end else if (bus.i_op == OP_MTHI) begin
              hi <= bus.i_data_A;
            end else if (bus.i_op == OP_MTLO) begin
              lo <= bus.i_data_A;
            end
          end
        end

        CALC: begin
          if (is_div) begin
            acc <= acc_div_next;
            rem <= rem_div_next;
          end else begin
            acc <= acc_mul_next;
          end
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (is_div) begin
            // Divide by zero leaves the remainder equal to the dividend; only LO is forced.
            lo <= div_zero ? '1 : (neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]);
            hi <= neg_r ? -rem : rem;
          end else begin
            {hi, lo} <= neg_q ? -acc : acc;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy = busy;
  assign bus.o_done = done;
  assign bus.o_hi   = hi;
  assign bus.o_lo   = lo;

endmodule
